// File: rtl/booth_mult_arbiter_pkg.sv
// Package booth_arb_defs: shared definitions for the Booth multiplier arbiter.
//   state_t : FSM state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   clog2   : index width helper; returns at least 1 so that a 1-requester
//             build still gets a legal vector width.
package booth_arb_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 31; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req     in  NREQ         request levels
//   pointer in  clog2(NREQ)  highest-priority index this round
//   grant   out NREQ         one-hot winner (all zero when req is zero)
//   index   out clog2(NREQ)  winner index (0 when req is zero)
module rr_arbiter
   import booth_arb_defs::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]        req,
   input  logic [clog2(NREQ)-1:0] pointer,
   output logic [NREQ-1:0]        grant,
   output logic [clog2(NREQ)-1:0] index
);

   localparam int unsigned IDW = clog2(NREQ);

   logic              found;
   logic [IDW-1:0]    cand;

   // Scan from the pointer upwards, wrapping modulo NREQ; first hit wins.
   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = IDW'((32'(pointer) + i) % NREQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: shares one radix-4 Booth multiplier between NREQ clients.
//   clk, reset            clock, synchronous active-high reset
//   req                   per-requester request level
//   mplier_in, mpcand_in  packed operands, slice i belongs to req[i]
//   ack                   one-cycle completion pulse to the granted requester
//   result, err           product (or 0 with err=1 on watchdog timeout)
//   busy                  high outside IDLE
//   grant_id              current or last granted requester
//   mul_mplier/mpcand     latched operands to the multiplier
//   mul_reset, mul_go     multiplier load strobe and run enable
//   mul_pdt, mul_over     multiplier product and completion flag
module booth_mult_arbiter
   import booth_arb_defs::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   mplier_in,
   input  logic [NREQ*WIDTH-1:0]   mpcand_in,
   output logic [NREQ-1:0]         ack,
   output logic [2*WIDTH-1:0]      result,
   output logic                    err,
   output logic                    busy,
   output logic [clog2(NREQ)-1:0]  grant_id,
   output logic [WIDTH-1:0]        mul_mplier,
   output logic [WIDTH-1:0]        mul_mpcand,
   output logic                    mul_reset,
   output logic                    mul_go,
   input  logic [2*WIDTH-1:0]      mul_pdt,
   input  logic                    mul_over
);

   localparam int unsigned IDW = clog2(NREQ);
   localparam int unsigned CW  = clog2(TIMEOUT);

   state_t          state, next_state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  win_idx;
   logic [NREQ-1:0] win_grant;
   logic [CW-1:0]   wd_cnt;
   logic            timed_out;
   logic            any_req;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req     (req),
      .pointer (ptr),
      .grant   (win_grant),
      .index   (win_idx)
   );

   assign any_req   = |win_grant;
   assign timed_out = (wd_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      next_state = state;
      ack        = '0;
      busy       = (state != IDLE);
      mul_go     = 1'b0;
      mul_reset  = reset;
      case (state)
         IDLE: if (any_req) next_state = LOAD;
         LOAD: begin
            mul_reset  = 1'b1;
            next_state = RUN;
         end
         RUN: begin
            mul_go = 1'b1;
            if (mul_over || timed_out) next_state = DONE;
         end
         DONE: begin
            ack[grant_id] = 1'b1;
            next_state    = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         grant_id   <= '0;
         mul_mplier <= '0;
         mul_mpcand <= '0;
         result     <= '0;
         err        <= 1'b0;
         wd_cnt     <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id   <= win_idx;
                  mul_mplier <= mplier_in[32'(win_idx) * WIDTH +: WIDTH];
                  mul_mpcand <= mpcand_in[32'(win_idx) * WIDTH +: WIDTH];
               end
            end
            LOAD: wd_cnt <= '0;
            RUN: begin
               wd_cnt <= wd_cnt + 1'b1;
               // A completion in the last watchdog cycle still counts as success.
               if (mul_over) begin
                  result <= mul_pdt;
                  err    <= 1'b0;
               end else if (timed_out) begin
                  result <= '0;
                  err    <= 1'b1;
               end
            end
            DONE: ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Testbench for booth_mult_arbiter with a cycle-stepped radix-4 Booth
// multiplier behind it. Expected grants come from a round-robin model over
// the request set; expected products come from plain signed multiplication.
module tb_booth_mult_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] mplier_in, mpcand_in;
   logic [3:0]  ack;
   logic [15:0] result;
   logic        err, busy;
   logic [1:0]  grant_id;
   logic [7:0]  mul_mplier, mul_mpcand;
   logic        mul_reset, mul_go;
   logic [15:0] mul_pdt;
   logic        mul_over;

   int checks = 0;
   int errors = 0;
   int rr_ptr = 0;
   bit force_low = 1'b0;

   always #5 clk = ~clk;

   booth_mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req),
      .mplier_in(mplier_in), .mpcand_in(mpcand_in),
      .ack(ack), .result(result), .err(err), .busy(busy), .grant_id(grant_id),
      .mul_mplier(mul_mplier), .mul_mpcand(mul_mpcand),
      .mul_reset(mul_reset), .mul_go(mul_go),
      .mul_pdt(mul_pdt), .mul_over(mul_over)
   );

   // Radix-4 Booth multiplier: one recoded digit per mul_go cycle.
   logic signed [7:0] m_a;
   logic [8:0]        m_b;
   int                m_acc, m_step, booth_d, booth_next;
   logic              m_done;
   logic [15:0]       m_pdt = '0;

   assign mul_pdt  = m_pdt;
   assign mul_over = m_done & ~force_low;

   always_comb begin
      booth_d = 0;
      case (m_b[2*m_step +: 3])
         3'b001, 3'b010: booth_d = 1;
         3'b011:         booth_d = 2;
         3'b100:         booth_d = -2;
         3'b101, 3'b110: booth_d = -1;
         default:        booth_d = 0;
      endcase
      booth_next = m_acc + ((booth_d * int'(m_a)) <<< (2 * m_step));
   end

   always @(posedge clk) begin
      if (mul_reset) begin
         m_a    <= mul_mpcand;
         m_b    <= {mul_mplier, 1'b0};
         m_acc  <= 0;
         m_step <= 0;
         m_done <= 1'b0;
      end else if (mul_go && !m_done) begin
         m_acc  <= booth_next;
         m_step <= m_step + 1;
         if (m_step == WIDTH / 2 - 1) begin
            m_done <= 1'b1;
            m_pdt  <= booth_next[15:0];
         end
      end
   end

   // ---------------- reference helpers ----------------
   function automatic int pick(input logic [3:0] r, input int p);
      for (int i = 0; i < NREQ; i++) begin
         int c;
         c = (p + i) % NREQ;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
      int x;
      x = int'($signed(a)) * int'($signed(b));
      return x[15:0];
   endfunction

   function automatic logic [3:0] oh(input int i);
      logic [3:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [15:0] prod_of(input int i);
      return prod(mplier_in[i*8 +: 8], mpcand_in[i*8 +: 8]);
   endfunction

   task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
      mplier_in[i*8 +: 8] = a;
      mpcand_in[i*8 +: 8] = b;
   endtask

   task automatic rand_ops(input int i);
      set_ops(i, 8'($urandom), 8'($urandom));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      rr_ptr = 0;
   endtask

   // Waits (bounded) for the next ack; sampled on the falling edge.
   task automatic wait_ack(output logic [3:0] av, output logic [15:0] res,
                           output logic e, output int waited, output int go_cycles,
                           output bit got);
      got = 1'b0; av = '0; res = '0; e = 1'b0; waited = 0; go_cycles = 0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         waited++;
         if (mul_go) go_cycles++;
         if (ack != '0) begin
            got = 1'b1; av = ack; res = result; e = err;
         end
      end
   endtask

   logic [3:0]  av;
   logic [15:0] res;
   logic        e;
   int          w, g;
   bit          got;

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; req = '0; mplier_in = '0; mpcand_in = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (ack !== 4'b0 || result !== 16'h0 || err !== 1'b0 || busy !== 1'b0 ||
          grant_id !== 2'd0 || mul_mplier !== 8'h0 || mul_mpcand !== 8'h0 ||
          mul_go !== 1'b0 || mul_reset !== 1'b1) begin
         errors++;
         $display("FAIL reset_values ack=%b res=%h err=%b busy=%b gid=%0d ops=%h/%h go=%b mrst=%b, required 0 0 0 0 0 0/0 0 1",
                  ack, result, err, busy, grant_id, mul_mplier, mul_mpcand, mul_go, mul_reset);
      end
      reset = 1'b0; rr_ptr = 0;
      @(negedge clk);
      checks++;
      if (mul_reset !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release mul_reset=%b busy=%b, required 0 0", mul_reset, busy);
      end
   endtask

   task automatic test_single();
      set_ops(0, 8'd13, 8'd27);
      req = 4'b0001;
      wait_ack(av, res, e, w, g, got);
      req = '0;
      checks++;
      if (!got || av !== 4'b0001) begin
         errors++; $display("FAIL single_ack got=%0d ack=%b, required 0001", got, av);
      end
      checks++;
      if (res !== 16'h015F || e !== 1'b0) begin
         errors++; $display("FAIL single_result res=%h err=%b, required 015f 0", res, e);
      end
      checks++;
      if (grant_id !== 2'd0) begin
         errors++; $display("FAIL single_grant_id got=%0d, required 0", grant_id);
      end
      // grant, one LOAD cycle, WIDTH/2 Booth steps, over seen, then DONE
      checks++;
      if (w !== 3 + WIDTH / 2) begin
         errors++; $display("FAIL single_latency got=%0d, required %0d", w, 3 + WIDTH / 2);
      end
      rr_ptr = 1;
      @(negedge clk);
      checks++;
      if (ack !== 4'b0) begin
         errors++; $display("FAIL single_ack_width ack=%b, required 0000", ack);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (result !== 16'h015F || busy !== 1'b0) begin
         errors++; $display("FAIL single_hold res=%h busy=%b, required 015f 0", result, busy);
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] exp_tab [2];
      int          ex;
      do_reset();
      exp_tab[0] = 16'hFF51;
      exp_tab[1] = 16'hFECE;
      set_ops(0, 8'd25, -8'sd7);
      set_ops(2, -8'sd18, 8'd17);
      req = 4'b0101;
      for (int j = 0; j < 2; j++) begin
         ex = pick(req, rr_ptr);
         wait_ack(av, res, e, w, g, got);
         req[ex] = 1'b0;
         rr_ptr  = (ex + 1) % NREQ;
         checks++;
         if (!got || av !== oh(ex) || res !== exp_tab[j] || e !== 1'b0) begin
            errors++;
            $display("FAIL simul_job%0d got=%0d ack=%b res=%h err=%b, required %b %h 0",
                     j, got, av, res, e, oh(ex), exp_tab[j]);
         end
      end
      // Pointer should now be 3: with 0 and 3 both requesting, 3 wins.
      rand_ops(0); rand_ops(3);
      req = 4'b1001;
      ex  = pick(req, rr_ptr);
      wait_ack(av, res, e, w, g, got);
      req = '0;
      checks++;
      if (!got || av !== oh(ex) || res !== prod_of(ex)) begin
         errors++;
         $display("FAIL simul_pointer got=%0d ack=%b res=%h, required %b %h", got, av, res, oh(ex), prod_of(ex));
      end
      rr_ptr = (ex + 1) % NREQ;
   endtask

   task automatic test_all_busy();
      int ex;
      set_ops(0, -8'sd19, -8'sd33);
      set_ops(1, 8'd0, 8'd5);
      set_ops(2, 8'd18, -8'sd8);
      rand_ops(3);
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         logic [15:0] ep;
         ex = pick(req, rr_ptr);
         ep = prod_of(ex);
         wait_ack(av, res, e, w, g, got);
         checks++;
         if (!got || av !== oh(ex) || res !== ep || e !== 1'b0 || grant_id !== 2'(ex)) begin
            errors++;
            $display("FAIL all_busy_job%0d got=%0d ack=%b res=%h err=%b gid=%0d, required %b %h 0 %0d",
                     j, got, av, res, e, grant_id, oh(ex), ep, ex);
         end
         rr_ptr = (ex + 1) % NREQ;
         if (j == 0) rand_ops(0);
         if (j == 4) req = '0;
      end
   endtask

   task automatic test_timeout();
      int ex;
      force_low = 1'b1;
      rand_ops(1);
      req = 4'b0010;
      ex  = pick(req, rr_ptr);
      wait_ack(av, res, e, w, g, got);
      req = '0;
      checks++;
      if (!got || av !== oh(ex) || res !== 16'h0 || e !== 1'b1) begin
         errors++;
         $display("FAIL timeout_job got=%0d ack=%b res=%h err=%b, required %b 0000 1", got, av, res, e, oh(ex));
      end
      checks++;
      if (g !== TIMEOUT) begin
         errors++; $display("FAIL timeout_run_cycles got=%0d, required %0d", g, TIMEOUT);
      end
      rr_ptr = (ex + 1) % NREQ;
      force_low = 1'b0;
      rand_ops(2);
      req = 4'b0100;
      ex  = pick(req, rr_ptr);
      wait_ack(av, res, e, w, g, got);
      req = '0;
      checks++;
      if (!got || av !== oh(ex) || res !== prod_of(ex) || e !== 1'b0) begin
         errors++;
         $display("FAIL timeout_recover got=%0d ack=%b res=%h err=%b, required %b %h 0", got, av, res, e, oh(ex), prod_of(ex));
      end
      rr_ptr = (ex + 1) % NREQ;
   endtask

   task automatic test_reset_midrun();
      int ex;
      bit seen;
      rand_ops(0);
      req = 4'b0001;
      ex  = pick(req, rr_ptr);
      wait_ack(av, res, e, w, g, got);
      req = '0;
      rr_ptr = (ex + 1) % NREQ;
      rand_ops(2);
      req  = 4'b0100;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (mul_go) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL midrun_reach_run mul_go never observed, required 1");
      end
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ack !== 4'b0 || mul_reset !== 1'b1 || mul_go !== 1'b0) begin
         errors++;
         $display("FAIL midrun_abort busy=%b ack=%b mul_reset=%b mul_go=%b, required 0 0000 1 0", busy, ack, mul_reset, mul_go);
      end
      @(negedge clk);
      checks++;
      if (mul_reset !== 1'b1 || ack !== 4'b0) begin
         errors++; $display("FAIL midrun_hold mul_reset=%b ack=%b, required 1 0000", mul_reset, ack);
      end
      reset  = 1'b0;
      rr_ptr = 0;
      rand_ops(0); rand_ops(1);
      req = 4'b0011;
      ex  = pick(req, rr_ptr);
      wait_ack(av, res, e, w, g, got);
      req = '0;
      checks++;
      if (!got || av !== oh(ex) || res !== prod_of(ex)) begin
         errors++;
         $display("FAIL midrun_pointer got=%0d ack=%b res=%h, required %b %h", got, av, res, oh(ex), prod_of(ex));
      end
      rr_ptr = (ex + 1) % NREQ;
   endtask

   task automatic test_withdraw();
      logic [15:0] ep;
      bit          seen;
      int          ex;
      rand_ops(3);
      ep  = prod_of(3);
      req = 4'b1000;
      ex  = pick(req, rr_ptr);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      // After grant: scramble requester 3's operands, briefly raise req[1].
      set_ops(3, ~mplier_in[31:24], 8'($urandom));
      req = 4'b0010;
      repeat (2) @(negedge clk);
      req = '0;
      wait_ack(av, res, e, w, g, got);
      checks++;
      if (!seen || !got || av !== oh(ex) || res !== ep) begin
         errors++;
         $display("FAIL withdraw_job busy_seen=%0d got=%0d ack=%b res=%h, required 1 1 %b %h", seen, got, av, res, oh(ex), ep);
      end
      rr_ptr = (ex + 1) % NREQ;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (ack != '0) seen = 1'b1;
      end
      checks++;
      if (seen || busy !== 1'b0) begin
         errors++; $display("FAIL withdraw_no_ack extra_ack=%0d busy=%b, required 0 0", seen, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  pending;
      logic [15:0] ep;
      int          ex;
      pending = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) rand_ops(i);
      req = pending;
      ex  = pick(pending, rr_ptr);
      ep  = prod_of(ex);
      for (int j = 0; j < 24; j++) begin
         wait_ack(av, res, e, w, g, got);
         checks++;
         if (!got || av !== oh(ex) || res !== ep || e !== 1'b0) begin
            errors++;
            $display("FAIL b2b_job%0d got=%0d ack=%b res=%h err=%b, required %b %h 0", j, got, av, res, e, oh(ex), ep);
         end
         rr_ptr = (ex + 1) % NREQ;
         pending[ex] = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (!pending[i] && ($urandom % 3 == 0)) begin
               rand_ops(i);
               pending[i] = 1'b1;
            end
         end
         if (pending == '0) begin
            int r;
            r = $urandom_range(0, NREQ - 1);
            rand_ops(r);
            pending[r] = 1'b1;
         end
         if (j == 23) pending = '0;
         req = pending;
         ex  = pick(pending, rr_ptr);
         if (ex >= 0) ep = prod_of(ex);
      end
   endtask

   initial begin
      reset = 1'b1; req = '0; mplier_in = '0; mpcand_in = '0;
      test_reset();
      test_single();
      test_simultaneous();
      test_all_busy();
      test_timeout();
      test_reset_midrun();
      test_withdraw();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation exceeded time limit, required completion");
      $fatal(1, "global timeout");
   end

endmodule
